flex_pts_framer: RTL and testbench
==================================

FLEX_PTS_FRAMER -- requirements
Module: flex_pts_framer

Interface
REQ-001 Parameter NUM_BITS, default 8: data word width; SHALL be >= 2.
REQ-002 Parameter SHIFT_MSB, default 1: 1 = MSB transmitted first, 0 = LSB first.
REQ-003 Parameter BIT_PERIOD, default 4: clock cycles per serial bit; SHALL be >= 1.
REQ-004 clk  input  1  clock, all state updated on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  NUM_BITS  parallel word to transmit.
REQ-007 data_valid  input  1  data_in holds a word to send.
REQ-008 data_ready  output  1  block accepts a word this cycle.
REQ-009 serial_out  output  1  serial line, idle high.
REQ-010 busy  output  1  frame in progress (state not IDLE).
REQ-011 frame_done  output  1  single-cycle pulse on final cycle of a frame.

Function
REQ-012 Handshake: word accepted on a rising edge where data_valid && data_ready; data_in captured into an internal shift register on that edge.
REQ-013 FSM states: IDLE, START, DATA, PARITY (macro only), STOP; each non-IDLE bit state holds its bit for exactly BIT_PERIOD cycles.
REQ-014 IDLE: serial_out = 1, data_ready = 1, busy = 0; on accept -> START next cycle.
REQ-015 START: serial_out = 0 for one bit period, then -> DATA.
REQ-016 DATA: NUM_BITS bits, MSB first if SHIFT_MSB = 1 else LSB first; register shifts one position at each bit-period boundary, vacated position filled with 1.
REQ-017 After the last data bit -> PARITY if compiled in, else -> STOP.
REQ-018 STOP: serial_out = 1 for one bit period; frame_done = 1 only in its last cycle.
REQ-019 data_ready SHALL also be 1 in the last STOP cycle; an accept there goes directly to START, with no idle gap between frames.
REQ-020 Last STOP cycle without accept -> IDLE.
REQ-021 data_valid while data_ready = 0 is ignored; data_in is not sampled and the frame in progress is unaffected.
REQ-022 Frame length = (NUM_BITS + 2) * BIT_PERIOD cycles, or (NUM_BITS + 3) * BIT_PERIOD with parity; first START cycle is the cycle after accept.
REQ-023 serial_out, data_ready, busy, frame_done SHALL be registered or decoded from registered state only, with no combinational path from data_valid.

Reset
REQ-024 n_rst low asynchronously forces IDLE, serial_out = 1, data_ready = 1 after release, busy = 0, frame_done = 0, shift register all ones, counters zero.
REQ-025 Reset mid-frame aborts the frame with no frame_done; first accept after release starts a fresh frame.

Configuration
REQ-026 Macro FLEX_PTS_PARITY_EN defined: PARITY state emits even parity (XOR of the captured word) for one bit period between DATA and STOP.
REQ-027 Macro FLEX_PTS_PARITY_EN undefined: no PARITY state, no parity logic; DATA -> STOP directly.

Structure
REQ-028 Package flex_pts_pkg SHALL hold the state enum typedef (IDLE, START, DATA, PARITY, STOP) and the frame-overhead constants (2 without parity, 3 with parity).
REQ-029 Sub-module flex_counter (parametrised rollover counter, clear and enable inputs, rollover flag) SHALL be instantiated twice: bit-period timer (rollover BIT_PERIOD) and data-bit index (rollover NUM_BITS).

Verification
REQ-030 NUM_BITS=8, BIT_PERIOD=4, SHIFT_MSB=0, no parity, send 0xA5 -> serial_out 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; frame_done in cycle 40 after accept.
REQ-031 Same setup, SHIFT_MSB=1, send 0xA5 -> data bits 1,0,1,0,0,1,0,1 (MSB first); busy high for 40 cycles.
REQ-032 Back-to-back: data_valid held high with 0x00 then 0xFF -> second START begins the cycle after the first frame_done; serial_out never idles high between the frames.
REQ-033 data_valid pulsed with 0x3C during DATA of a frame carrying 0x81 -> 0x3C never transmitted; 0x81 frame bit-exact.
REQ-034 n_rst asserted in DATA bit 3 -> serial_out = 1 within the same cycle, busy = 0, no frame_done; next word after release transmits correctly.
REQ-035 FLEX_PTS_PARITY_EN defined, send 0x07 -> parity bit 1 after the data bits; frame 44 cycles; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/flex_pts_pkg.sv
// Shared types and constants for the flex_pts serial framer.
// Frame overhead counts start/stop bits, plus parity when enabled.
package flex_pts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } pts_state_t;

    localparam int FRAME_OVH_BASE   = 2;
    localparam int FRAME_OVH_PARITY = 3;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 0..ROLLOVER-1 while enabled.
// rollover is decoded from the registered count (high on the final value).
module flex_counter #(
    parameter int ROLLOVER = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic rollover
);

    localparam int W = (ROLLOVER > 1) ? $clog2(ROLLOVER) : 1;
    localparam logic [W-1:0] LAST = W'(ROLLOVER - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= rollover ? '0 : count + 1'b1;
        end
    end

    assign rollover = (count == LAST);

endmodule

// File: rtl/flex_pts_framer.sv
// Parallel-to-serial framer: start bit, data bits, optional even parity
// (FLEX_PTS_PARITY_EN), stop bit; back-to-back frames without idle gap.
module flex_pts_framer
    import flex_pts_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 1,
    parameter int BIT_PERIOD = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    pts_state_t state, next_state;

    logic                tick;
    logic                last_bit;
    logic                stop_end;
    logic                accept;
    logic                sr_bit;
    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] sr_shifted;

    flex_counter #(.ROLLOVER(BIT_PERIOD)) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (state == IDLE),
        .enable   (state != IDLE),
        .rollover (tick)
    );

    flex_counter #(.ROLLOVER(NUM_BITS)) u_bit_index (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (state != DATA),
        .enable   (state == DATA && tick),
        .rollover (last_bit)
    );

    assign stop_end   = (state == STOP) && tick;
    assign data_ready = (state == IDLE) || stop_end;
    assign busy       = (state != IDLE);
    assign frame_done = stop_end;
    assign accept     = data_valid && data_ready;

    always_comb begin
        if (SHIFT_MSB != 0) begin
            sr_bit     = sr[NUM_BITS-1];
            sr_shifted = {sr[NUM_BITS-2:0], 1'b1};
        end else begin
            sr_bit     = sr[0];
            sr_shifted = {1'b1, sr[NUM_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr <= '1;
        end else if (accept) begin
            sr <= data_in;
        end else if (state == DATA && tick) begin
            sr <= sr_shifted;
        end
    end

`ifdef FLEX_PTS_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^data_in;
        end
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        serial_out = 1'b1;
        unique case (state)
            IDLE: begin
                if (accept) next_state = START;
            end
            START: begin
                serial_out = 1'b0;
                if (tick) next_state = DATA;
            end
            DATA: begin
                serial_out = sr_bit;
                if (tick && last_bit) begin
`ifdef FLEX_PTS_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef FLEX_PTS_PARITY_EN
            PARITY: begin
                serial_out = parity_bit;
                if (tick) next_state = STOP;
            end
`endif
            STOP: begin
                // An accept in the final stop cycle chains straight into START.
                if (tick) next_state = accept ? START : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_flex_pts_framer.sv
// Directed bench for flex_pts_framer: LSB-first and MSB-first instances
// driven in parallel, each frame checked cycle by cycle.
module tb_flex_pts_framer;
    import flex_pts_pkg::*;

    localparam int N  = 8;
    localparam int BP = 4;
`ifdef FLEX_PTS_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int OVH = FRAME_OVH_PARITY;
`else
    localparam bit PAR = 1'b0;
    localparam int OVH = FRAME_OVH_BASE;
`endif
    localparam int FL = (N + OVH) * BP;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic [N-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic ready_l, ser_l, busy_l, done_l;
    logic ready_m, ser_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flex_pts_framer #(.NUM_BITS(N), .SHIFT_MSB(0), .BIT_PERIOD(BP)) u_lsb (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_l),
        .serial_out (ser_l),
        .busy       (busy_l),
        .frame_done (done_l)
    );

    flex_pts_framer #(.NUM_BITS(N), .SHIFT_MSB(1), .BIT_PERIOD(BP)) u_msb (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_m),
        .serial_out (ser_m),
        .busy       (busy_m),
        .frame_done (done_m)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [N-1:0] w, input bit msb,
                                     input int c);
        int slot;
        slot = (c - 1) / BP;
        if (slot == 0) return 1'b0;
        if (slot <= N) return msb ? w[N-slot] : w[slot-1];
        if (PAR && slot == N + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic accept_word(input logic [N-1:0] w);
        @(negedge clk);
        data_valid = 1'b1;
        data_in    = w;
        check("ready_before_accept", ready_l, 1);
        check("ready_before_accept_msb", ready_m, 1);
        @(posedge clk);
    endtask

    // mode 0: drop valid; 1: hold valid with aux as next word;
    // 2: pulse aux mid-frame while busy
    task automatic check_frame(input logic [N-1:0] w, input int mode,
                               input logic [N-1:0] aux);
        for (int c = 1; c <= FL; c++) begin
            @(negedge clk);
            check($sformatf("ser_lsb %0h c%0d", w, c), ser_l, exp_bit(w, 1'b0, c));
            check($sformatf("ser_msb %0h c%0d", w, c), ser_m, exp_bit(w, 1'b1, c));
            check($sformatf("busy %0h c%0d", w, c), busy_l, 1);
            check($sformatf("busy_msb %0h c%0d", w, c), busy_m, 1);
            check($sformatf("done %0h c%0d", w, c), done_l, c == FL);
            check($sformatf("done_msb %0h c%0d", w, c), done_m, c == FL);
            check($sformatf("ready %0h c%0d", w, c), ready_l, c == FL);
            if (c == 1) begin
                if (mode == 1) data_in = aux;
                else data_valid = 1'b0;
            end
            if (mode == 2 && c == 10) begin
                data_valid = 1'b1;
                data_in    = aux;
            end
            if (mode == 2 && c == 11) data_valid = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_ser"}, ser_l, 1);
        check({tag, "_ser_msb"}, ser_m, 1);
        check({tag, "_busy"}, busy_l, 0);
        check({tag, "_ready"}, ready_l, 1);
        check({tag, "_done"}, done_l, 0);
    endtask

    initial begin
        #1 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ser", ser_l, 1);
        check("rst_busy", busy_l, 0);
        check("rst_done", done_l, 0);
        n_rst = 1'b1;
        check_idle("post_reset");

        accept_word(8'hA5);
        check_frame(8'hA5, 0, 8'h00);
        check_idle("after_a5");

        accept_word(8'h00);
        check_frame(8'h00, 1, 8'hFF);
        check_frame(8'hFF, 0, 8'h00);
        check_idle("after_b2b");

        accept_word(8'h81);
        check_frame(8'h81, 2, 8'h3C);
        check_idle("after_81");

        // abort in data bit 3 of 0xC3 (bit value 0), LSB instance
        accept_word(8'hC3);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_abort_ser", ser_l, 0);
        n_rst = 1'b0;
        #1;
        check("abort_ser", ser_l, 1);
        check("abort_ser_msb", ser_m, 1);
        check("abort_busy", busy_l, 0);
        check("abort_done", done_l, 0);
        @(negedge clk);
        check("abort_done_hold", done_l, 0);
        n_rst = 1'b1;
        check_idle("after_abort");

        accept_word(8'h5A);
        check_frame(8'h5A, 0, 8'h00);
        check_idle("after_5a");

        accept_word(8'h07);
        check_frame(8'h07, 0, 8'h00);
        accept_word(8'h03);
        check_frame(8'h03, 0, 8'h00);
        check_idle("after_parity");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
